// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encodings, wait-counter width and decode helper
package mem_bus_arbiter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;
   localparam int WCNT_W = 4;
   function automatic int ram_bit(input int aw);
      return aw - 1;
   endfunction
endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter with a zero flag for wait-state insertion
module mem_wait_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   input  logic         i_dec,
   output logic [W-1:0] o_cnt,
   output logic         o_zero
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk) begin
      if (reset) r_cnt <= '0;
      else if (i_load) r_cnt <= i_val;
      else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   end
   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the CPU memory bus between fetch and data ports with ROM/RAM wait states
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over IF.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int AW       = 12,
   parameter int DW       = 8,
   parameter int ROM_WAIT = 1,
   parameter int RAM_WAIT = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          d_err,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          rom_sel,
   output logic          ram_sel,
   output logic          mem_rd,
   output logic          mem_wr
);
   localparam int RB = ram_bit(AW);

   if (ROM_WAIT < 0 || ROM_WAIT > 15 || RAM_WAIT < 0 || RAM_WAIT > 15) begin : g_bad_wait
      $error("mem_bus_arbiter: ROM_WAIT/RAM_WAIT must be within 0..15");
   end

   state_t              r_state, w_next;
   logic                r_gnt_d, r_we, r_ram;
   logic [AW-1:0]       r_addr;
   logic [DW-1:0]       r_wdata, r_rdata;
   logic                w_any, w_pick_d, w_load, w_zero, w_acc, w_done, w_req_ram;
   logic [AW-1:0]       w_req_addr;
   logic [WCNT_W-1:0]   w_wait, w_cnt;

   assign w_any = if_req | d_req;

`ifdef MEM_ARB_RR_EN
   logic r_pref_d;
   // Points at the port that was not served last; starts out favouring D.
   always_ff @(posedge clk) begin
      if (reset) r_pref_d <= 1'b1;
      else if (w_load) r_pref_d <= !w_pick_d;
   end
   assign w_pick_d = d_req & (!if_req | r_pref_d);
`else
   assign w_pick_d = d_req;
`endif

   assign w_load     = (r_state == ST_IDLE) & w_any;
   assign w_req_addr = w_pick_d ? d_addr : if_addr;
   assign w_req_ram  = w_req_addr[RB];
   assign w_wait     = w_req_ram ? WCNT_W'(RAM_WAIT) : WCNT_W'(ROM_WAIT);

   mem_wait_counter #(.W(WCNT_W)) u_wcnt (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_val  (w_wait),
      .i_dec  (w_acc),
      .o_cnt  (w_cnt),
      .o_zero (w_zero)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   w_next = w_any ? ST_ACCESS : ST_IDLE;
         ST_ACCESS: w_next = w_zero ? ST_DONE : ST_ACCESS;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_gnt_d <= 1'b0;
         r_we    <= 1'b0;
         r_ram   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_gnt_d <= w_pick_d;
            r_we    <= w_pick_d & d_we;
            r_ram   <= w_req_ram;
            r_addr  <= w_req_addr;
            r_wdata <= w_pick_d ? d_wdata : '0;
         end
         // Writes return no data, so a ROM write reports zero alongside d_err.
         if (w_acc && w_zero) r_rdata <= r_we ? '0 : mem_rdata;
      end
   end

   assign w_acc     = (r_state == ST_ACCESS);
   assign w_done    = (r_state == ST_DONE);
   assign rom_sel   = w_acc & !r_ram;
   assign ram_sel   = w_acc & r_ram;
   assign mem_rd    = w_acc & !r_we;
   assign mem_wr    = w_acc & r_we & r_ram;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_ack    = w_done & !r_gnt_d;
   assign d_ack     = w_done & r_gnt_d;
   assign if_rdata  = if_ack ? r_rdata : '0;
   assign d_rdata   = d_ack ? r_rdata : '0;
   assign d_err     = d_ack & r_we & !r_ram;

   logic w_unused;
   assign w_unused = ^w_cnt;
endmodule
